acq_cnt_irq_gen: RTL and testbench
==================================

// Module: acq_cnt_irq_gen
// PURPOSE
// - DSO acquisition sequencer upstream of the CNT_IRQ PIO input: counts pre-/post-trigger samples,
//   drives capture-RAM write enable/address, and raises cnt_irq (wired to the PIO in_port) when done.
// - The NIOS2 polls cnt_irq, reads trig_addr to unroll the ring buffer, then pulses irq_clr.
// PARAMETERS
// - CNT_W   16  width of pre_depth/post_depth and internal sample counters
// - ADDR_W  12  capture RAM address width; ring buffer of 2^ADDR_W samples
// PORTS
// - clk        in   1       system clock
// - reset_n    in   1       async active-low reset
// - arm        in   1       1-cycle pulse, start acquisition (accepted only in IDLE)
// - abort      in   1       return to IDLE from any state
// - sample_en  in   1       ADC sample strobe, one sample per high cycle
// - trig_in    in   1       trigger comparator output (synchronous); rising edge detected internally
// - pre_depth  in   CNT_W   pre-trigger samples, latched on accepted arm
// - post_depth in   CNT_W   post-trigger samples, latched on accepted arm; 0 treated as 1
// - irq_clr    in   1       CPU acknowledge; DONE -> IDLE
// - wr_en      out  1       capture RAM write strobe (combinational)
// - wr_addr    out  ADDR_W  registered write pointer; RAM writes at wr_addr when wr_en
// - trig_addr  out  ADDR_W  wr_addr captured in the trigger cycle
// - state      out  3       0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
// - cnt_irq    out  1       registered completion flag to PIO
// BEHAVIOUR
// - Reset: state=IDLE, wr_addr=0, trig_addr=0, cnt_irq=0, counters=0, trig_d=0; wr_en=0.
// - trig_edge = trig_in & ~trig_d; trig_d registered every cycle in all states.
// - wr_en = sample_en & (state==PRE|WAIT|POST); wr_addr += 1 (mod 2^ADDR_W) on each wr_en.
// - IDLE: arm -> latch depths; wr_addr<=0; pre_cnt<=0; next PRE, or WAIT if pre_depth==0.
// - PRE: sample_en increments pre_cnt; sample_en with pre_cnt==pre_depth-1 -> WAIT.
//   trig_edge in PRE is ignored (no premature trigger).
// - WAIT: writes continue, wrapping over oldest data.
//   trig_edge -> trig_addr<=wr_addr, post_cnt<=sample_en, next POST.
// - Trigger-cycle sample (if sample_en) is written at trig_addr and counts as post sample 1.
// - POST: sample_en increments post_cnt; the write at post_cnt==post_depth-1 is the last -> DONE.
//   Trigger cycle itself completes the capture when eff. post_depth==1 and sample_en.
//   trig_edge ignored in POST.
// - DONE: cnt_irq=1 from the first DONE cycle, held; wr_en=0; arm ignored.
//   irq_clr -> cnt_irq<=0, IDLE next cycle.
// - abort (any state, priority over all else): next IDLE, cnt_irq<=0; wr_addr/trig_addr hold.
// - irq_clr outside DONE: no effect. arm outside IDLE: no effect.
// - Reset mid-operation: immediate return to reset values; no partial completion flag.
// - Counters saturate-free: comparisons only against latched depth-1.
//   Depths > 2^ADDR_W are legal; the ring simply overwrites.
// TESTING
// - pre=4, post=8, sample_en every cycle:
//   edge after 4 writes -> trig_addr=4, 8 post writes (addr 4..11), cnt_irq=1 the cycle after addr 11.
// - pre=4, trig_edge at sample 2 (PRE) then held high:
//   no trigger; a later new rising edge in WAIT is accepted.
// - ADDR_W=4, pre=4, 20 WAIT samples before edge:
//   wr_addr wraps 15->0; trig_addr=(4+20) mod 16=8.
// - abort during POST at post_cnt=3:
//   state=IDLE next cycle, wr_en=0, cnt_irq stays 0; a fresh arm restarts with wr_addr=0.
// - DONE held 50 cycles with arm pulses:
//   cnt_irq stays 1, no writes; irq_clr -> cnt_irq=0, state=IDLE next cycle.
// - pre=0, post=0, sample_en on trigger cycle:
//   arm -> WAIT directly; single write at trig_addr; DONE next cycle.

Source files
------------

// File: rtl/acq_cnt_irq_gen.sv
// Acquisition sequencer for the DSO capture path.
// It counts pre-trigger and post-trigger samples into a ring buffer and drives
// the capture RAM write strobe and pointer. It raises cnt_irq for the PIO when
// a capture completes, and holds it until the CPU acknowledges.
module acq_cnt_irq_gen #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              sample_en,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  pre_depth,
    input  logic [CNT_W-1:0]  post_depth,
    input  logic              irq_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [2:0]        state,
    output logic              cnt_irq
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic              r_trig_d;
    logic              r_cnt_irq;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [CNT_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_post_cnt;
    logic [CNT_W-1:0]  r_pre_depth;
    logic [CNT_W-1:0]  r_post_depth;

    logic              w_trig_edge;
    logic              w_active;
    logic              w_wr_en;
    logic              w_pre_last;
    logic              w_post_last;
    logic              w_arm_accept;
    logic              w_trig_take;

    assign w_trig_edge = trig_in & ~r_trig_d;
    assign w_active    = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_wr_en     = sample_en & w_active;
    assign w_pre_last  = (r_pre_cnt == (r_pre_depth - CNT_ONE));
    assign w_post_last = (r_post_cnt == (r_post_depth - CNT_ONE));

    assign wr_en     = w_wr_en;
    assign wr_addr   = r_wr_addr;
    assign trig_addr = r_trig_addr;
    assign state     = r_state;
    assign cnt_irq   = r_cnt_irq;

    // Next-state decode; abort outranks every other event
    always_comb begin
        w_next_state = r_state;
        w_arm_accept = 1'b0;
        w_trig_take  = 1'b0;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_arm_accept = 1'b1;
                        w_next_state = (pre_depth == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (sample_en && w_pre_last) begin
                        w_next_state = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_trig_edge) begin
                        w_trig_take  = 1'b1;
                        w_next_state = (sample_en && (r_post_depth == CNT_ONE)) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (sample_en && w_post_last) begin
                        w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (irq_clr) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register; the completion flag is simply "next state is DONE", registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt_irq <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt_irq <= (w_next_state == ST_DONE);
        end
    end

    // Write pointer, trigger address, sample counters and latched depths (all hold on abort)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_d     <= 1'b0;
            r_wr_addr    <= '0;
            r_trig_addr  <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_pre_depth  <= '0;
            r_post_depth <= '0;
        end else begin
            r_trig_d <= trig_in;
            if (!abort) begin
                if (w_arm_accept) begin
                    r_pre_depth  <= pre_depth;
                    r_post_depth <= (post_depth == '0) ? CNT_ONE : post_depth;
                    r_wr_addr    <= '0;
                    r_pre_cnt    <= '0;
                end else if (w_wr_en) begin
                    r_wr_addr <= r_wr_addr + ADDR_ONE;
                end
                if ((r_state == ST_PRE) && sample_en) begin
                    r_pre_cnt <= r_pre_cnt + CNT_ONE;
                end
                if (w_trig_take) begin
                    r_trig_addr <= r_wr_addr;
                    r_post_cnt  <= {{(CNT_W-1){1'b0}}, sample_en};
                end else if ((r_state == ST_POST) && sample_en) begin
                    r_post_cnt <= r_post_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_acq_cnt_irq_gen.sv
// Scoreboard bench for acq_cnt_irq_gen.
// The driver feeds a countdown-style reference model and queues the expected
// per-cycle outputs. A negedge monitor pops each record and compares it
// against the DUT.
module tb_acq_cnt_irq_gen;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 4;
    localparam int RING   = 1 << ADDR_W;
    localparam int P_IDLE = 0, P_PRE = 1, P_WAIT = 2, P_POST = 3, P_DONE = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              arm, abort, sample_en, trig_in, irq_clr;
    logic [CNT_W-1:0]  pre_depth, post_depth;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, trig_addr;
    logic [2:0]        state;
    logic              cnt_irq;

    typedef struct {
        int wrEn;
        int wrAddr;
        int st;
        int irq;
        int trigAddr;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    bit   scoreOn = 1'b0;

    int   mPhase, mAddr, mTrigAddr, preLeft, postLeft, postDepthEff;
    int   mIrq, mTrigPrev;

    acq_cnt_irq_gen #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort),
        .sample_en(sample_en), .trig_in(trig_in), .pre_depth(pre_depth),
        .post_depth(post_depth), .irq_clr(irq_clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .trig_addr(trig_addr), .state(state), .cnt_irq(cnt_irq)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = P_IDLE; mAddr = 0; mTrigAddr = 0; mIrq = 0; mTrigPrev = 0;
        preLeft = 0; postLeft = 0; postDepthEff = 1;
    endtask

    // Reference model: remaining-sample countdowns per acquisition phase
    task automatic modelStep(input int a, input int ab, input int se, input int tr,
                             input int ic, input int pre, input int post);
        int edgeSeen;
        edgeSeen  = (tr != 0) && (mTrigPrev == 0);
        mTrigPrev = tr;
        if (ab != 0) begin
            mPhase = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE: if (a != 0) begin
                    preLeft      = pre;
                    postDepthEff = (post == 0) ? 1 : post;
                    mAddr        = 0;
                    mPhase       = (pre == 0) ? P_WAIT : P_PRE;
                end
                P_PRE: if (se != 0) begin
                    mAddr = (mAddr + 1) % RING;
                    preLeft--;
                    if (preLeft == 0) mPhase = P_WAIT;
                end
                P_WAIT: begin
                    if (edgeSeen) begin
                        mTrigAddr = mAddr;
                        postLeft  = postDepthEff - ((se != 0) ? 1 : 0);
                        mPhase    = (postLeft == 0) ? P_DONE : P_POST;
                    end
                    if (se != 0) mAddr = (mAddr + 1) % RING;
                end
                P_POST: if (se != 0) begin
                    mAddr = (mAddr + 1) % RING;
                    postLeft--;
                    if (postLeft == 0) mPhase = P_DONE;
                end
                P_DONE: if (ic != 0) mPhase = P_IDLE;
                default: mPhase = P_IDLE;
            endcase
        end
        mIrq = (mPhase == P_DONE) ? 1 : 0;
    endtask

    // Drive one cycle of inputs, queue what the DUT should show, advance the model
    task automatic applyStimulus(input int a, input int ab, input int se, input int tr,
                                 input int ic, input int pre, input int post);
        exp_t e;
        int   seEff;
        seEff      = (ab != 0) ? 0 : se;
        arm        = (a != 0);
        abort      = (ab != 0);
        sample_en  = (seEff != 0);
        trig_in    = (tr != 0);
        irq_clr    = (ic != 0);
        pre_depth  = CNT_W'(pre);
        post_depth = CNT_W'(post);
        e.st       = mPhase;
        e.irq      = mIrq;
        e.wrEn     = ((seEff != 0) && (mPhase >= P_PRE) && (mPhase <= P_POST)) ? 1 : 0;
        e.wrAddr   = mAddr;
        e.trigAddr = mTrigAddr;
        expQ.push_back(e);
        modelStep(a, ab, seEff, tr, ic, pre, post);
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input int n, input int tr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, tr, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle out of reset the DUT presents state/pointer/flag; compare with the queue head
    always @(negedge clk) begin
        exp_t e;
        if (scoreOn && reset_n && (expQ.size() > 0)) begin
            e = expQ.pop_front();
            checkOutput("state", int'(state), e.st);
            checkOutput("cnt_irq", int'(cnt_irq), e.irq);
            checkOutput("wr_en", int'(wr_en), e.wrEn);
            checkOutput("wr_addr", int'(wr_addr), e.wrAddr);
            checkOutput("trig_addr", int'(trig_addr), e.trigAddr);
        end
    end

    initial begin
        reset_n = 1'b0;
        arm = 0; abort = 0; sample_en = 1; trig_in = 0; irq_clr = 0;
        pre_depth = '0; post_depth = '0;
        modelReset();
        #12;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_irq", int'(cnt_irq), 0);
        checkOutput("reset_wr_en", int'(wr_en), 0);
        checkOutput("reset_wr_addr", int'(wr_addr), 0);
        checkOutput("reset_trig_addr", int'(trig_addr), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        scoreOn = 1'b1;
        idle(2);

        // pre=4, post=8, sample every cycle
        $display("[TB] pre=4 post=8 continuous samples");
        applyStimulus(1, 0, 1, 0, 0, 4, 8);
        samples(4, 0);
        samples(8, 1);
        checkOutput("t1_irq", int'(cnt_irq), 1);
        checkOutput("t1_trig_addr", int'(trig_addr), 4);
        checkOutput("t1_wr_addr", int'(wr_addr), 12);
        idle(2);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Early rising edge in PRE must be ignored; a fresh edge in WAIT triggers
        $display("[TB] early trigger in PRE ignored");
        applyStimulus(1, 0, 1, 0, 0, 4, 3);
        samples(1, 0);
        samples(3, 1);
        samples(3, 1);
        samples(1, 0);
        samples(3, 1);
        checkOutput("t2_trig_addr", int'(trig_addr), 8);
        checkOutput("t2_irq", int'(cnt_irq), 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Ring wrap: 20 WAIT samples before the edge
        $display("[TB] ring wrap");
        applyStimulus(1, 0, 1, 0, 0, 4, 2);
        samples(24, 0);
        samples(2, 1);
        checkOutput("t3_trig_addr", int'(trig_addr), 8);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Abort in POST at post_cnt=3, then re-arm from address 0
        $display("[TB] abort during POST");
        applyStimulus(1, 0, 1, 0, 0, 2, 8);
        samples(2, 0);
        samples(3, 1);
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        checkOutput("t4_state", int'(state), 0);
        checkOutput("t4_irq", int'(cnt_irq), 0);
        samples(3, 0);
        applyStimulus(1, 0, 1, 0, 0, 3, 1);
        samples(3, 0);
        samples(1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // DONE held 50 cycles under arm pulses and samples
        $display("[TB] DONE hold");
        applyStimulus(1, 0, 1, 0, 0, 1, 1);
        samples(1, 0);
        samples(1, 1);
        for (int i = 0; i < 50; i++) applyStimulus((i % 5) == 0, 0, 1, i % 2, 0, 2, 2);
        checkOutput("t5_irq_held", int'(cnt_irq), 1);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        checkOutput("t5_state_clr", int'(state), 0);
        checkOutput("t5_irq_clr", int'(cnt_irq), 0);
        idle(2);

        // pre=0, post=0: straight to WAIT, single write on the trigger cycle
        $display("[TB] zero depths");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_state_wait", int'(state), 2);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("t6_irq", int'(cnt_irq), 1);
        checkOutput("t6_trig_addr", int'(trig_addr), 0);
        checkOutput("t6_wr_addr", int'(wr_addr), 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Randomised traffic against the model
        $display("[TB] random traffic");
        begin
            int tr;
            tr = 0;
            for (int i = 0; i < 4000; i++) begin
                int a, ab, se, ic, pre, post;
                a  = ($urandom_range(0, 5) == 0);
                ab = ($urandom_range(0, 59) == 0);
                se = ($urandom_range(0, 3) != 0);
                ic = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 4) == 0) tr = 1 - tr;
                pre  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 40)) : int'($urandom_range(0, 6));
                post = int'($urandom_range(0, 6));
                applyStimulus(a, ab, se, tr, ic, pre, post);
            end
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Asynchronous reset in the middle of a capture
        $display("[TB] reset mid-capture");
        applyStimulus(1, 0, 1, 0, 0, 2, 5);
        samples(2, 0);
        samples(2, 1);
        scoreOn = 1'b0;
        reset_n = 1'b0;
        #2;
        checkOutput("t8_state", int'(state), 0);
        checkOutput("t8_irq", int'(cnt_irq), 0);
        checkOutput("t8_wr_en", int'(wr_en), 0);
        checkOutput("t8_wr_addr", int'(wr_addr), 0);
        checkOutput("t8_trig_addr", int'(trig_addr), 0);
        expQ.delete();
        modelReset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        scoreOn = 1'b1;
        idle(2);
        applyStimulus(1, 0, 1, 0, 0, 1, 1);
        samples(1, 0);
        samples(1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(3);

        scoreOn = 1'b0;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
